// File: rtl/fp_int_pkg.sv
// Shared fp16 constants and accumulator FSM encoding for the fp16 x int dot-product path.
package fp_int_pkg;

  localparam int FP16_BIAS   = 15;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    NORM  = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/fp_int_norm.sv
// Combinational normaliser: leading-one detect on |acc|, then fp16 pack with
// saturate-to-max-finite on exponent overflow and flush-to-zero on underflow.
module fp_int_norm
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_WIDTH = FP16_EXP_W,
  parameter int FRAC_BITS = FP16_FRAC_W
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [EXP_WIDTH-1:0] i_acc_exp,
  output logic [15:0]          o_fp16
);

  localparam int QW      = $clog2(ACC_WIDTH);
  localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

  logic                 w_sign;
  logic [ACC_WIDTH-1:0] w_mag;
  logic [ACC_WIDTH-1:0] w_norm;
  logic [QW-1:0]        w_q;
  int                   w_e;

  always_comb begin
    w_sign = i_acc[ACC_WIDTH-1];
    w_mag  = w_sign ? -i_acc : i_acc;
    w_q    = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (w_mag[i]) w_q = QW'(i);
    end
    w_e = int'(w_q) + int'(i_acc_exp) - FRAC_BITS;

    // Place the leading one at bit FRAC_BITS so the fraction sits directly below it.
    if (int'(w_q) >= FRAC_BITS) w_norm = w_mag >> (int'(w_q) - FRAC_BITS);
    else                        w_norm = w_mag << (FRAC_BITS - int'(w_q));

    if (w_mag == '0)         o_fp16 = 16'h0000;
    else if (w_e >= EXP_MAX) o_fp16 = {w_sign, FP16_MAX_FINITE};
    else if (w_e <= 0)       o_fp16 = {w_sign, 15'h0000};
    else                     o_fp16 = {w_sign, w_e[EXP_WIDTH-1:0], w_norm[FRAC_BITS-1:0]};
  end

endmodule

// File: rtl/fp_int_acc.sv
// Aligns signed fp16-exponent products to a running shared exponent, accumulates,
// and emits one normalised fp16 result per dot product over valid/ready.
module fp_int_acc
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int MANT_WIDTH = 14,
  parameter int EXP_WIDTH  = FP16_EXP_W,
  parameter int FRAC_BITS  = FP16_FRAC_W,
  parameter int BIAS       = FP16_BIAS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_acc,
  input  logic                  sign_in,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic [MANT_WIDTH-1:0] mantissa_in,
  input  logic                  last,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_fp16,
  output logic                  ovf_err,
  output logic                  drop_err
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [EXP_WIDTH-1:0] r_acc_exp;
  logic                 r_empty;
  logic                 r_out_valid;
  logic [15:0]          r_out_fp16;
  logic                 r_ovf_err;
  logic                 r_drop_err;

  logic [ACC_WIDTH-1:0] w_p;
  logic [ACC_WIDTH-1:0] w_a;
  logic [ACC_WIDTH-1:0] w_b;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [EXP_WIDTH-1:0] w_d;
  logic                 w_up;
  logic                 w_ovf;
  logic [15:0]          w_norm_fp16;

  function automatic logic [ACC_WIDTH-1:0] asr(input logic [ACC_WIDTH-1:0] x,
                                               input logic [EXP_WIDTH-1:0] d);
    if (int'(d) >= ACC_WIDTH) asr = {ACC_WIDTH{x[ACC_WIDTH-1]}};
    else                      asr = ACC_WIDTH'($signed(x) >>> d);
  endfunction

  always_comb begin
    w_p  = {{(ACC_WIDTH-MANT_WIDTH){1'b0}}, mantissa_in};
    if (sign_in) w_p = -w_p;
    w_up = exp_in > r_acc_exp;
    w_d  = w_up ? (exp_in - r_acc_exp) : (r_acc_exp - exp_in);
    w_a  = w_up ? asr(r_acc, w_d) : r_acc;
    w_b  = w_up ? w_p : asr(w_p, w_d);
    w_sum = {w_a[ACC_WIDTH-1], w_a} + {w_b[ACC_WIDTH-1], w_b};
    // Sign-extended sum disagreeing in its top two bits means the signed add overflowed.
    w_ovf = !r_empty && (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]);
    if (r_empty)    w_acc_next = w_p;
    else if (w_ovf) w_acc_next = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else            w_acc_next = w_sum[ACC_WIDTH-1:0];
  end

  fp_int_norm #(
    .ACC_WIDTH (ACC_WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_norm (
    .i_acc     (r_acc),
    .i_acc_exp (r_acc_exp),
    .o_fp16    (w_norm_fp16)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_acc_exp   <= '0;
      r_empty     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_fp16  <= '0;
      r_ovf_err   <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      if (start_acc && r_state != ACCUM) r_drop_err <= 1'b1;
      case (r_state)
        ACCUM: begin
          if (start_acc) begin
            r_acc   <= w_acc_next;
            r_empty <= 1'b0;
            if (r_empty || w_up) r_acc_exp <= exp_in;
            if (w_ovf) r_ovf_err <= 1'b1;
            if (last) r_state <= NORM;
          end
        end
        NORM: begin
          r_out_fp16  <= w_norm_fp16;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_empty     <= 1'b1;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_fp16  = r_out_fp16;
  assign ovf_err   = r_ovf_err;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_fp_int_acc.sv
// Directed checks of fp_int_acc: pack/normalise, alignment, saturation, backpressure, reset.
module tb_fp_int_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_acc;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [13:0] mantissa_in;
  logic        last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_fp16;
  logic        ovf_err;
  logic        drop_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_int_acc dut (
    .clk         (clk),
    .rst         (rst),
    .start_acc   (start_acc),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mantissa_in (mantissa_in),
    .last        (last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp16    (out_fp16),
    .ovf_err     (ovf_err),
    .drop_err    (drop_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; presents one strobe across the next rising edge.
  task automatic send(input logic s, input logic [4:0] e, input logic [13:0] m, input logic l);
    start_acc   = 1'b1;
    sign_in     = s;
    exp_in      = e;
    mantissa_in = m;
    last        = l;
    @(negedge clk);
    start_acc   = 1'b0;
    last        = 1'b0;
  endtask

  // Called right after the last strobe: checks latency, value, then accepts it.
  task automatic expect_result(input string tag, input logic [15:0] exp_v);
    check({tag, "_norm_vld"}, 16'(out_valid), 16'd0);
    check({tag, "_norm_rdy"}, 16'(in_ready), 16'd0);
    @(negedge clk);
    check({tag, "_vld"}, 16'(out_valid), 16'd1);
    check({tag, "_val"}, out_fp16, exp_v);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 16'(out_valid), 16'd0);
    check({tag, "_rdy_back"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1; start_acc = 1'b0; sign_in = 1'b0; exp_in = '0;
    mantissa_in = '0; last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld",  16'(out_valid), 16'd0);
    check("rst_fp16", out_fp16, 16'h0000);
    check("rst_rdy",  16'(in_ready), 16'd1);
    check("rst_ovf",  16'(ovf_err), 16'd0);
    check("rst_drop", 16'(drop_err), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    send(1'b0, 5'd15, 14'h0400, 1'b1);
    expect_result("one", 16'h3C00);

    send(1'b0, 5'd15, 14'h0400, 1'b0);
    send(1'b0, 5'd15, 14'h0400, 1'b1);
    expect_result("two", 16'h4000);

    send(1'b0, 5'd15, 14'h0C00, 1'b1);
    expect_result("c00", 16'h4200);

    send(1'b0, 5'd16, 14'h0400, 1'b0);
    send(1'b1, 5'd15, 14'h0400, 1'b1);
    expect_result("mix_hi_first", 16'h3C00);

    send(1'b1, 5'd15, 14'h0400, 1'b0);
    send(1'b0, 5'd16, 14'h0400, 1'b1);
    expect_result("mix_lo_first", 16'h3C00);

    send(1'b1, 5'd15, 14'h0400, 1'b1);
    expect_result("neg_one", 16'hBC00);

    send(1'b0, 5'd30, 14'h3C00, 1'b1);
    expect_result("sat_max", 16'h7BFF);

    send(1'b0, 5'd15, 14'h0400, 1'b0);
    send(1'b1, 5'd15, 14'h0400, 1'b1);
    expect_result("cancel", 16'h0000);

    send(1'b0, 5'd0, 14'h0400, 1'b1);
    expect_result("flush", 16'h0000);

    // Backpressure with a dropped strobe inside the stall window.
    send(1'b0, 5'd15, 14'h0800, 1'b1);
    @(negedge clk);
    check("bp_vld", 16'(out_valid), 16'd1);
    check("bp_val0", out_fp16, 16'h4000);
    send(1'b0, 5'd20, 14'h3FFF, 1'b1);
    check("bp_drop", 16'(drop_err), 16'd1);
    for (int i = 0; i < 2; i++) begin
      check("bp_hold_val", out_fp16, 16'h4000);
      check("bp_hold_vld", 16'(out_valid), 16'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_vld_drop", 16'(out_valid), 16'd0);
    check("bp_rdy", 16'(in_ready), 16'd1);
    send(1'b0, 5'd15, 14'h0400, 1'b1);
    expect_result("after_drop", 16'h3C00);
    check("drop_sticky", 16'(drop_err), 16'd1);

    // Reset mid-accumulation discards the partial sum.
    send(1'b0, 5'd20, 14'h0400, 1'b0);
    send(1'b0, 5'd20, 14'h0400, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_vld",  16'(out_valid), 16'd0);
    check("mrst_fp16", out_fp16, 16'h0000);
    check("mrst_drop", 16'(drop_err), 16'd0);
    check("mrst_rdy",  16'(in_ready), 16'd1);
    send(1'b0, 5'd15, 14'h0400, 1'b1);
    expect_result("post_rst", 16'h3C00);
    check("no_ovf", 16'(ovf_err), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_int_acc.md
Name: fp_int_acc

Overview:
- Downstream consumer of the fp16 x bit-serial-int multiplier stage.
- Takes one partial product per `start_acc` pulse: sign, 5-bit fp16 exponent, and 14-bit fixed-point mantissa sum (4 integer bits, 10 fraction bits).
- Aligns each product to a running shared exponent and accumulates in two's complement.
- On the product flagged `last`, normalises the sum and emits one fp16 dot-product result through a valid/ready handshake.

Parameters:
- ACC_WIDTH, 32, width of the signed accumulator register.
- MANT_WIDTH, 14, width of the incoming product mantissa.
- EXP_WIDTH, 5, exponent width (fp16).
- FRAC_BITS, 10, fraction bits in the incoming mantissa and in the fp16 output.
- BIAS, 15, fp16 exponent bias.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start_acc  input  1  product strobe; sign_in/exp_in/mantissa_in/last valid this cycle
- sign_in  input  1  product sign (1 = negative)
- exp_in  input  EXP_WIDTH  biased fp16 exponent of the product
- mantissa_in  input  MANT_WIDTH  unsigned product magnitude
- last  input  1  qualified by start_acc; final product of the current dot product
- in_ready  output  1  high when a start_acc will be accepted
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_fp16  output  16  result {sign, exp[4:0], frac[9:0]}
- ovf_err  output  1  sticky; accumulator add saturated
- drop_err  output  1  sticky; start_acc arrived while in_ready=0

Behaviour:
- Reset (async, rst=1):
  - State=ACCUM; acc=0, acc_exp=0, empty=1.
  - out_valid=0, out_fp16=0, ovf_err=0, drop_err=0, in_ready=1.
- Product value: (-1)^sign_in * mantissa_in * 2^(exp_in - BIAS - FRAC_BITS).
- Accumulator value: acc * 2^(acc_exp - BIAS - FRAC_BITS).
- State ACCUM (in_ready=1). On start_acc:
  - p = sign_in ? -zext(mantissa_in) : zext(mantissa_in), ACC_WIDTH bits.
  - If empty: acc<=p, acc_exp<=exp_in, empty<=0.
  - Else if exp_in > acc_exp: acc<=(acc >>> d)+p, with d=exp_in-acc_exp; acc_exp<=exp_in.
  - Else: acc<=acc+(p >>> d), with d=acc_exp-exp_in.
  - Shifts are arithmetic and truncating. d >= ACC_WIDTH yields 0 or -1.
  - Signed overflow saturates acc to the most-positive or most-negative value and sets ovf_err.
  - Single-cycle update; back-to-back start_acc on consecutive cycles is supported.
  - If last=1 on the strobe: the product is included, then next state=NORM.
- State NORM (1 cycle, in_ready=0). Form s=acc<0 and mag=|acc|.
  - mag=0: out_fp16<=16'h0000.
  - Otherwise, with q = index of the leading one of mag and e = q + acc_exp - FRAC_BITS:
    - e >= 31: out_fp16<={s,15'h7BFF} (saturate to max finite).
    - e <= 0: out_fp16<={s,15'h0} (flush to zero).
    - Otherwise: frac = the 10 bits below the leading one (truncate if q>10, zero-pad if q<10); out_fp16<={s,e[4:0],frac}.
  - Then: out_valid<=1, state=OUT.
- State OUT (in_ready=0):
  - Hold out_fp16 and out_valid stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0, acc<=0, empty<=1, state=ACCUM.
  - in_ready=1 starts the next cycle.
- Latency: last strobe at cycle t -> out_valid high at t+2 (registered in NORM).
- A start_acc while in_ready=0 (NORM/OUT) is ignored and sets drop_err. Accumulator state is untouched.
- ovf_err and drop_err clear only on reset.
- Reset asserted mid-accumulation or in OUT: immediately returns to reset values; a pending result is lost.
- exp_in=0 is treated as a normal exponent; upstream always supplies an implicit leading 1.

Decomposition:
- Package fp_int_pkg holds:
  - Constants: FP16_BIAS, FP16_EXP_W, FP16_FRAC_W, FP16_MAX_FINITE=15'h7BFF.
  - State enum {ACCUM, NORM, OUT}.
- One sub-module: fp_int_norm, combinational. Leading-one detect plus fp16 pack/saturate/flush from (acc, acc_exp).

Test Plan:
- Single product sign=0, exp=15, mant=0x400, last=1 -> out_fp16=0x3C00 two cycles later; in_ready low until accepted.
- Two products (exp15, 0x400) then (exp15, 0x400, last) -> 0x4000. Single product (exp15, 0xC00, last) -> 0x4200.
- Mixed exponent and sign:
  - (exp16, 0x400, +) then (exp15, 0x400, −, last) -> acc=0x200, acc_exp=16 -> 0x3C00.
  - Reversed order gives the same result.
- Saturation and cancellation:
  - (exp30, 0x3C00, +, last) -> 0x7BFF.
  - (exp15, 0x400, +) then (exp15, 0x400, −, last) -> 0x0000.
- Backpressure: hold out_ready=0 for 3 cycles -> out_fp16 stable. A start_acc during that window -> drop_err=1 and no effect on the next result. out_ready=1 -> out_valid drops next cycle and in_ready=1.
- Assert rst for 1 cycle mid-accumulation after 2 products -> all outputs 0. A fresh single product (exp15, 0x400, last) then yields 0x3C00.
